// File: rtl/i2c_rx.sv
// I2C write-only target receiver: oversampled SCL/SDA, START/STOP detection,
// 7-bit address match with ACK, and a per-byte write strobe with byte index.
module i2c_rx #(
    parameter logic [6:0]  ADDR  = 7'h28,
    parameter int unsigned BYTES = 2,
    localparam int unsigned IW   = (BYTES > 1) ? $clog2(BYTES) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          scl_in,
    input  logic          sda_in,
    output logic          sda_oe,
    output logic          wr_en,
    output logic [7:0]    data_out,
    output logic [IW-1:0] index_out,
    output logic          busy,
    output logic          done
);

    localparam int unsigned CW = $clog2(BYTES + 1);
    localparam int unsigned BW = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_DATA,
        S_DATA_ACK,
        S_IGNORE
    } state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [CW-1:0]   byte_cnt_q, byte_cnt_d;
    logic            sda_oe_d, wr_en_d, busy_d, done_d;
    logic [7:0]      data_out_d;
    logic [IW-1:0]   index_out_d;

    logic scl_s1, scl_s2, scl_prev;
    logic sda_s1, sda_s2, sda_prev;
    logic scl_rise, scl_fall, start_det, stop_det;

    // Two-flop synchronisers plus previous-value registers; idle bus reads high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_s1   <= 1'b1;
            scl_s2   <= 1'b1;
            scl_prev <= 1'b1;
            sda_s1   <= 1'b1;
            sda_s2   <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_s1   <= scl_in;
            scl_s2   <= scl_s1;
            scl_prev <= scl_s2;
            sda_s1   <= sda_in;
            sda_s2   <= sda_s1;
            sda_prev <= sda_s2;
        end
    end

    assign scl_rise  =  scl_s2 & ~scl_prev;
    assign scl_fall  = ~scl_s2 &  scl_prev;
    assign start_det =  scl_s2 &  scl_prev &  sda_prev & ~sda_s2;
    assign stop_det  =  scl_s2 &  scl_prev & ~sda_prev &  sda_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            byte_cnt_q <= '0;
            sda_oe     <= 1'b0;
            wr_en      <= 1'b0;
            data_out   <= '0;
            index_out  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            byte_cnt_q <= byte_cnt_d;
            sda_oe     <= sda_oe_d;
            wr_en      <= wr_en_d;
            data_out   <= data_out_d;
            index_out  <= index_out_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        byte_cnt_d  = byte_cnt_q;
        sda_oe_d    = sda_oe;
        wr_en_d     = 1'b0;
        data_out_d  = data_out;
        index_out_d = index_out;
        busy_d      = busy;
        done_d      = 1'b0;

        if (start_det) begin
            state_d    = S_ADDR;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
            sda_oe_d   = 1'b0;
        end else if (stop_det) begin
            state_d  = S_IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            done_d   = busy && (byte_cnt_q != '0);
        end else begin
            case (state_q)
                S_ADDR, S_DATA: begin
                    if (scl_rise && (bit_cnt_q < BW'(8))) begin
                        shift_d   = {shift_q[6:0], sda_s2};
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end else if (scl_fall && (bit_cnt_q == BW'(8))) begin
                        bit_cnt_d = '0;
                        if (state_q == S_ADDR) begin
                            if ((shift_q[7:1] == ADDR) && !shift_q[0]) begin
                                state_d  = S_ADDR_ACK;
                                sda_oe_d = 1'b1;
                                busy_d   = 1'b1;
                            end else begin
                                state_d  = S_IGNORE;
                                sda_oe_d = 1'b0;
                            end
                        end else if (byte_cnt_q < CW'(BYTES)) begin
                            wr_en_d     = 1'b1;
                            data_out_d  = shift_q;
                            index_out_d = IW'(byte_cnt_q);
                            byte_cnt_d  = byte_cnt_q + CW'(1);
                            sda_oe_d    = 1'b1;
                            state_d     = S_DATA_ACK;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = S_IGNORE;
                        end
                    end
                end
                S_ADDR_ACK, S_DATA_ACK: begin
                    // ACK held through the ninth clock, released on its falling edge
                    if (scl_fall) begin
                        state_d   = S_DATA;
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = '0;
                    end
                end
                S_IGNORE: sda_oe_d = 1'b0;
                default:  state_d  = state_q;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_rx.sv
// Self-checking bench for i2c_rx: a bus-level I2C master drives directed and
// random write transactions; expectations come from a transaction-level model.
module tb_i2c_rx;

    localparam int H = 20;   // SCL half period in clk cycles

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scl_drv, sda_drv;
    logic       scl_in, sda_in;
    logic       sda_oe, wr_en, busy, done;
    logic [7:0] data_out;
    logic [0:0] index_out;

    int checks   = 0;
    int failures = 0;

    logic [8:0] wr_q[$];
    int         done_cnt = 0;
    logic [7:0] txn[0:7];

    i2c_rx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .sda_oe    (sda_oe),
        .wr_en     (wr_en),
        .data_out  (data_out),
        .index_out (index_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    assign scl_in = scl_drv;
    assign sda_in = sda_drv & ~sda_oe;   // open-drain wired-AND

    always @(negedge clk) begin
        if (wr_en === 1'b1) wr_q.push_back({index_out, data_out});
        if (done === 1'b1) done_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic i2c_start();
        sda_drv = 1'b0;
        tick(H);
        scl_drv = 1'b0;
        tick(H);
    endtask

    task automatic i2c_rstart();
        sda_drv = 1'b1;
        tick(H);
        scl_drv = 1'b1;
        tick(H);
        i2c_start();
    endtask

    task automatic i2c_stop();
        sda_drv = 1'b0;
        tick(H);
        scl_drv = 1'b1;
        tick(H);
        sda_drv = 1'b1;
        tick(H);
    endtask

    // Clocks out the top nbits of b, MSB first; target must not drive SDA
    task automatic send_bits(input logic [7:0] b, input int nbits);
        for (int i = 7; i > 7 - nbits; i--) begin
            sda_drv = b[i];
            tick(H);
            scl_drv = 1'b1;
            tick(H / 2);
            chk("oe_during_bit", 32'(sda_oe), 32'd0);
            tick(H / 2);
            scl_drv = 1'b0;
            tick(4);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        send_bits(b, 8);
        sda_drv = 1'b1;
        tick(H);
        scl_drv = 1'b1;
        tick(H / 2);
        ack = (sda_in == 1'b0);
        tick(H / 2);
        scl_drv = 1'b0;
        tick(4);
    endtask

    // Transaction-level model: address acks iff it names 7'h28 with write bit,
    // data byte k (0-based) acks and is written iff k < 2.
    task automatic run_txn(input int n, input string tag);
        logic       ack;
        logic       addr_ok;
        logic [8:0] exp_q[$];
        int         nwr;
        addr_ok = ((txn[0] >> 1) == 8'h28) && (txn[0] % 2 == 0);
        nwr = 0;
        i2c_start();
        for (int i = 0; i < n; i++) begin
            send_byte(txn[i], ack);
            if (i == 0) chk({tag, "_addr_ack"}, 32'(ack), 32'(addr_ok));
            else begin
                chk({tag, "_data_ack"}, 32'(ack), 32'(addr_ok && (i - 1) < 2));
                if (addr_ok && (i - 1) < 2) begin
                    exp_q.push_back({1'(i - 1), txn[i]});
                    nwr++;
                end
            end
        end
        i2c_stop();
        tick(10);
        chk({tag, "_busy_after_stop"}, 32'(busy), 32'd0);
        chk({tag, "_done_cnt"}, 32'(done_cnt), 32'((addr_ok && nwr > 0) ? 1 : 0));
        chk({tag, "_wr_cnt"}, 32'(wr_q.size()), 32'(nwr));
        for (int i = 0; i < nwr && i < wr_q.size(); i++)
            chk({tag, "_wr_entry"}, 32'(wr_q[i]), 32'(exp_q[i]));
    endtask

    task automatic clear_mon();
        wr_q.delete();
        done_cnt = 0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_sda_oe"},    32'(sda_oe),    32'd0);
        chk({tag, "_wr_en"},     32'(wr_en),     32'd0);
        chk({tag, "_data_out"},  32'(data_out),  32'd0);
        chk({tag, "_index_out"}, 32'(index_out), 32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk({tag, "_done"},      32'(done),      32'd0);
    endtask

    initial begin
        logic ack;
        rst_n   = 1'b0;
        scl_drv = 1'b1;
        sda_drv = 1'b1;
        tick(5);
        chk_reset_outputs("rst");
        rst_n = 1'b1;
        tick(10);

        // Basic two-byte write
        clear_mon();
        txn[0] = 8'h50; txn[1] = 8'h12; txn[2] = 8'h34;
        run_txn(3, "basic");
        chk("basic_last_data", 32'(data_out), 32'h34);
        chk("basic_last_index", 32'(index_out), 32'd1);

        // Wrong address
        clear_mon();
        txn[0] = 8'h52; txn[1] = 8'hFF;
        run_txn(2, "wrong_addr");

        // Read request
        clear_mon();
        txn[0] = 8'h51; txn[1] = 8'h77;
        run_txn(2, "read_req");

        // Third byte beyond capacity
        clear_mon();
        txn[0] = 8'h50; txn[1] = 8'hA1; txn[2] = 8'hB2; txn[3] = 8'hC3;
        run_txn(4, "overflow");

        // Repeated START restarts byte indexing
        clear_mon();
        i2c_start();
        send_byte(8'h50, ack); chk("rs_addr1_ack", 32'(ack), 32'd1);
        send_byte(8'h11, ack); chk("rs_data1_ack", 32'(ack), 32'd1);
        chk("rs_busy_mid", 32'(busy), 32'd1);
        i2c_rstart();
        send_byte(8'h50, ack); chk("rs_addr2_ack", 32'(ack), 32'd1);
        send_byte(8'h22, ack); chk("rs_data2_ack", 32'(ack), 32'd1);
        i2c_stop();
        tick(10);
        chk("rs_wr_cnt", 32'(wr_q.size()), 32'd2);
        if (wr_q.size() == 2) begin
            chk("rs_wr0", 32'(wr_q[0]), 32'h011);
            chk("rs_wr1", 32'(wr_q[1]), 32'h022);
        end
        chk("rs_done_cnt", 32'(done_cnt), 32'd1);
        chk("rs_busy_end", 32'(busy), 32'd0);

        // Reset in the middle of a data byte
        clear_mon();
        i2c_start();
        send_byte(8'h50, ack); chk("mr_addr_ack", 32'(ack), 32'd1);
        send_bits(8'hA5, 4);
        rst_n   = 1'b0;
        scl_drv = 1'b1;
        sda_drv = 1'b1;
        tick(3);
        chk_reset_outputs("mid_rst");
        tick(3);
        rst_n = 1'b1;
        tick(10);
        txn[0] = 8'h50; txn[1] = 8'h5A;
        run_txn(2, "post_rst");

        // Randomized transactions
        for (int t = 0; t < 12; t++) begin
            int n;
            int sel;
            clear_mon();
            n   = 1 + $urandom_range(0, 3);
            sel = $urandom_range(0, 3);
            txn[0] = (sel < 2) ? 8'h50 : (sel == 2) ? 8'h51 : 8'($urandom);
            for (int i = 1; i < n; i++) txn[i] = 8'($urandom);
            run_txn(n, "rand");
            tick($urandom_range(1, 30));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
